// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall scheduler for the 5-stage MIPS pipeline.
// Tracks the destinations of the EX, MEM and WB stages and derives the
// pipeline-register enables, bubbles, the IF/ID flush and the forwarding
// selects. It also freezes the pipe on data-memory wait states and counts
// stall and flush cycles.
//
// Handshake: the data-memory access in MEM is valid while mem_req is high
// and completes in the cycle where mem_ack is high; any cycle with
// mem_req && !mem_ack freezes every pipeline register.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             cpu_rst,
    input  logic             cpu_en,
    input  logic [4:0]       id_addr_rs,
    input  logic [4:0]       id_addr_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       id_regw_addr,
    input  logic             id_wb_wen,
    input  logic             id_mem_ren,
    input  logic             id_is_branch,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_bubble,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             wb_commit,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             id_fwd_rs,
    output logic             id_fwd_rt,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             dbg_state
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [WC_W-1:0] wcnt, wcnt_nxt;

    // Scoreboard slots. The ID use flags are only consumed in ID, and the
    // WB load flag has no consumer, so neither is kept downstream.
    logic       ex_wen, ex_ld, mem_wen, mem_ld, wb_wen;
    logic [4:0] ex_rd, ex_rs, ex_rt, mem_rd, wb_rd;

    logic freeze, hold, flush, ex_src_hit, mem_src_hit, luse, bhaz, err_set;

    // A slot produces register src when it writes it and src is not $0.
    function automatic logic hit(input logic wen, input logic [4:0] dst,
                                 input logic [4:0] src);
        return wen && (dst == src) && (src != 5'd0);
    endfunction

    // Hazard detection against the scoreboard.
    always_comb begin
        freeze      = mem_req && !mem_ack;
        ex_src_hit  = (id_use_rs && hit(ex_wen, ex_rd, id_addr_rs)) ||
                      (id_use_rt && hit(ex_wen, ex_rd, id_addr_rt));
        mem_src_hit = (id_use_rs && hit(mem_wen, mem_rd, id_addr_rs)) ||
                      (id_use_rt && hit(mem_wen, mem_rd, id_addr_rt));
        luse        = ex_ld && ex_src_hit;
        bhaz        = id_is_branch && (ex_src_hit || (mem_ld && mem_src_hit));
        hold        = (luse || bhaz) && !freeze;
        flush       = branch_taken && !hold && !freeze;
    end

    // Pipeline control and forwarding selects: reset > !cpu_en > freeze > hold > flush.
    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        wb_commit    = 1'b0;
        fwd_a_sel    = 2'b00;
        fwd_b_sel    = 2'b00;
        id_fwd_rs    = 1'b0;
        id_fwd_rt    = 1'b0;
        if (!cpu_rst) begin
            if (hit(mem_wen, mem_rd, ex_rs) && !mem_ld) fwd_a_sel = 2'b01;
            else if (hit(wb_wen, wb_rd, ex_rs))         fwd_a_sel = 2'b10;
            if (hit(mem_wen, mem_rd, ex_rt) && !mem_ld) fwd_b_sel = 2'b01;
            else if (hit(wb_wen, wb_rd, ex_rt))         fwd_b_sel = 2'b10;
            id_fwd_rs = id_is_branch && hit(mem_wen, mem_rd, id_addr_rs) && !mem_ld;
            id_fwd_rt = id_is_branch && hit(mem_wen, mem_rd, id_addr_rt) && !mem_ld;
            if (cpu_en && !freeze) begin
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
                mem_wb_en = 1'b1;
                wb_commit = 1'b1;
                if (hold) begin
                    id_ex_bubble = 1'b1;
                end else begin
                    pc_en       = 1'b1;
                    if_id_en    = 1'b1;
                    if_id_flush = flush;
                end
            end
        end
    end

    // Scoreboard shift: frozen slots hold, a hold drops a bubble into EX.
    always_ff @(posedge clk) begin
        if (cpu_rst) begin
            ex_wen  <= 1'b0; ex_ld  <= 1'b0; ex_rd <= 5'd0; ex_rs <= 5'd0; ex_rt <= 5'd0;
            mem_wen <= 1'b0; mem_ld <= 1'b0; mem_rd <= 5'd0;
            wb_wen  <= 1'b0; wb_rd  <= 5'd0;
        end else if (cpu_en && !freeze) begin
            wb_wen  <= mem_wen;
            wb_rd   <= mem_rd;
            mem_wen <= ex_wen;
            mem_rd  <= ex_rd;
            mem_ld  <= ex_ld;
            if (hold) begin
                ex_wen <= 1'b0; ex_ld <= 1'b0; ex_rd <= 5'd0; ex_rs <= 5'd0; ex_rt <= 5'd0;
            end else begin
                ex_wen <= id_wb_wen;
                ex_ld  <= id_mem_ren;
                ex_rd  <= id_regw_addr;
                ex_rs  <= id_addr_rs;
                ex_rt  <= id_addr_rt;
            end
        end
    end

    // Memory wait FSM next state; the wait counter saturates at the timeout.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        if (cpu_en) begin
            case (state)
                ST_RUN: begin
                    if (freeze) begin
                        state_nxt = ST_WAIT;
                        wcnt_nxt  = WC_W'(1);
                    end else begin
                        wcnt_nxt  = '0;
                    end
                end
                ST_WAIT: begin
                    if (freeze) begin
                        if (wcnt != WC_W'(MEM_TIMEOUT)) wcnt_nxt = wcnt + WC_W'(1);
                    end else begin
                        state_nxt = ST_RUN;
                        wcnt_nxt  = '0;
                    end
                end
                default: begin
                    state_nxt = ST_RUN;
                    wcnt_nxt  = '0;
                end
            endcase
        end
        err_set = cpu_en && freeze && (wcnt_nxt == WC_W'(MEM_TIMEOUT));
    end

    // FSM state, sticky timeout flag and performance counters.
    always_ff @(posedge clk) begin
        if (cpu_rst) begin
            state     <= ST_RUN;
            wcnt      <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (err_set) mem_err <= 1'b1;
            if (cpu_en && (freeze || hold)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (cpu_en && flush)            flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign dbg_state = (state == ST_WAIT);

endmodule
